// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller: PC, IR and start/stall/branch/halt sequencing
module fetch_sequencer #(
   parameter int                 ADDR_W    = 6,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] HALT_WORD = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_req,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [ADDR_W-1:0]  pc_addr,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  ir_pc,
   output logic               ir_valid,
   output logic               halted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_HALT  = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic [ADDR_W-1:0]    ir_pc_q, ir_pc_d;
   logic                 ir_valid_q, ir_valid_d;
   logic                 halted_q, halted_d;

   // Next-state and next-register logic; everything holds unless a rule below fires.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      halted_d   = halted_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_FETCH;
               pc_d       = '0;
               ir_valid_d = 1'b0;
            end
         end
         S_FETCH: begin
            // Branch beats stall: the redirect inserts a single flush bubble.
            if (branch_req) begin
               pc_d       = branch_target;
               ir_d       = '0;
               ir_valid_d = 1'b0;
            end else if (!stall) begin
               ir_d    = instr_in;
               ir_pc_d = pc_q;
               if (instr_in == HALT_WORD) begin
                  ir_valid_d = 1'b0;
                  halted_d   = 1'b1;
                  state_d    = S_HALT;
               end else begin
                  ir_valid_d = 1'b1;
                  pc_d       = pc_q + ADDR_W'(1);
               end
            end
         end
         S_HALT: begin
            if (start) begin
               state_d    = S_FETCH;
               pc_d       = '0;
               halted_d   = 1'b0;
               ir_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset overriding all inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         ir_q       <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
      end
   end

   assign pc_addr  = pc_q;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a behavioural fetch model
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        stall;
   logic        branch_req;
   logic [5:0]  branch_target;
   logic [31:0] instr_in;
   logic [5:0]  pc_addr;
   logic [31:0] ir;
   logic [5:0]  ir_pc;
   logic        ir_valid;
   logic        halted;

   logic [31:0] rom [64];

   int n_vec;
   int n_err;

   // model state: 0 idle, 1 running, 2 halted
   int          m_mode;
   logic [5:0]  m_pc;
   logic [31:0] m_ir;
   logic [5:0]  m_irpc;
   logic        m_v;
   logic        m_h;

   fetch_sequencer #(
      .ADDR_W(6),
      .INSTR_W(32),
      .HALT_WORD(32'h0000_0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .stall(stall),
      .branch_req(branch_req),
      .branch_target(branch_target),
      .instr_in(instr_in),
      .pc_addr(pc_addr),
      .ir(ir),
      .ir_pc(ir_pc),
      .ir_valid(ir_valid),
      .halted(halted)
   );

   assign instr_in = rom[pc_addr];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural fetch model applied once per rising edge.
   task automatic model_edge();
      logic [31:0] word;
      if (reset) begin
         m_mode = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_h = 0;
      end else if (m_mode == 0 || m_mode == 2) begin
         if (start) begin
            m_mode = 1; m_pc = 0; m_v = 0; m_h = 0;
         end
      end else begin
         word = rom[m_pc];
         if (branch_req) begin
            m_pc = branch_target; m_ir = 0; m_v = 0;
         end else if (!stall) begin
            m_ir = word; m_irpc = m_pc;
            if (word == 32'h0) begin
               m_v = 0; m_h = 1; m_mode = 2;
            end else begin
               m_v = 1; m_pc = 6'((int'(m_pc) + 1) % 64);
            end
         end
      end
   endtask

   task automatic check_model();
      check("pc_addr", 32'(pc_addr), 32'(m_pc));
      check("ir", ir, m_ir);
      check("ir_pc", 32'(ir_pc), 32'(m_irpc));
      check("ir_valid", 32'(ir_valid), 32'(m_v));
      check("halted", 32'(halted), 32'(m_h));
   endtask

   task automatic cycle(input logic r, input logic s, input logic st, input logic br, input logic [5:0] bt);
      reset = r; start = s; stall = st; branch_req = br; branch_target = bt;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic run_until_pc(input logic [5:0] target);
      for (int i = 0; i < 70; i++) begin
         if (pc_addr == target) break;
         cycle(0, 0, 0, 0, 0);
      end
      check("reach_pc", 32'(pc_addr), 32'(target));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_mode = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0; m_h = 0;
      for (int a = 0; a < 64; a++) rom[a] = (a <= 10) ? ($urandom | 32'h1) : 32'h0;

      // reset state
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      check("rst_pc", 32'(pc_addr), 32'd0);
      check("rst_valid", 32'(ir_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      cycle(0, 0, 0, 0, 0);

      // straight-line run into the halt word at address 11
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i <= 10; i++) begin
         cycle(0, 0, 0, 0, 0);
         check("line_irpc", 32'(ir_pc), 32'(i));
         check("line_ir", ir, rom[i]);
      end
      cycle(0, 0, 0, 0, 0);
      check("halt_h", 32'(halted), 32'd1);
      check("halt_v", 32'(ir_valid), 32'd0);
      check("halt_pc", 32'(pc_addr), 32'd11);
      cycle(0, 0, 1, 1, 6'd9);
      check("halt_ign_br", 32'(pc_addr), 32'd11);

      // restart from HALT
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      check("restart_irpc", 32'(ir_pc), 32'd0);

      // stall for three cycles at pc 4
      run_until_pc(6'd4);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 0, 0);
         check("stall_pc", 32'(pc_addr), 32'd4);
         check("stall_irpc", 32'(ir_pc), 32'd3);
      end
      cycle(0, 0, 0, 0, 0);
      check("unstall_irpc", 32'(ir_pc), 32'd4);

      // branch, then branch together with stall
      for (int k = 0; k < 2; k++) begin
         run_until_pc(6'd7);
         cycle(0, 0, k[0], 1, 6'd2);
         check("br_valid", 32'(ir_valid), 32'd0);
         check("br_pc", 32'(pc_addr), 32'd2);
         cycle(0, 0, 0, 0, 0);
         check("br_irpc", 32'(ir_pc), 32'd2);
      end

      // reset mid-run with stall and branch asserted
      run_until_pc(6'd5);
      cycle(1, 0, 1, 1, 6'd9);
      check("mrst_pc", 32'(pc_addr), 32'd0);
      check("mrst_ir", ir, 32'd0);
      check("mrst_valid", 32'(ir_valid), 32'd0);
      check("mrst_halted", 32'(halted), 32'd0);
      cycle(0, 0, 0, 0, 0);
      check("idle_hold_pc", 32'(pc_addr), 32'd0);

      // start held during FETCH has no effect
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
      check("start_ign_irpc", 32'(ir_pc), 32'd3);

      // wrap-around with a fully populated ROM
      for (int a = 0; a < 64; a++) rom[a] = $urandom | 32'h1;
      cycle(0, 0, 0, 1, 6'd63);
      check("wrap_pc63", 32'(pc_addr), 32'd63);
      cycle(0, 0, 0, 0, 0);
      check("wrap_irpc63", 32'(ir_pc), 32'd63);
      check("wrap_pc0", 32'(pc_addr), 32'd0);
      cycle(0, 0, 0, 0, 0);
      check("wrap_irpc0", 32'(ir_pc), 32'd0);
      check("wrap_pc1", 32'(pc_addr), 32'd1);
      check("wrap_halted", 32'(halted), 32'd0);

      // randomized run against the model, ROM with sparse halt words
      for (int a = 0; a < 64; a++) rom[a] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 10),
               ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 12),
               6'($urandom_range(0, 63)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
